maxpool_user_sequencer: RTL and testbench

MAXPOOL_USER_SEQUENCER -- requirements
Module: maxpool_user_sequencer

---
 rtl/maxpool_user_sequencer_pkg.sv | 33 +++
 rtl/maxpool_user_sequencer_if.sv | 24 ++
 rtl/maxpool_seq_counter.sv | 38 +++
 rtl/maxpool_user_sequencer.sv | 126 ++++++++++++
 tb/tb_maxpool_user_sequencer.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/maxpool_user_sequencer_pkg.sv
// rtl/maxpool_user_sequencer_pkg.sv - shared sizes, tuser bit map and FSM encoding for the maxpool sequencer
`ifndef UNITS
`define UNITS 2
`endif
`ifndef GROUPS
`define GROUPS 1
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 8
`endif
`ifndef KERNEL_W_MAX
`define KERNEL_W_MAX 5
`endif
`ifndef TUSER_WIDTH_MAXPOOL_IN
`define TUSER_WIDTH_MAXPOOL_IN 5
`endif

package maxpool_user_sequencer_pkg;
  localparam int DEF_UNITS        = `UNITS;
  localparam int DEF_GROUPS       = `GROUPS;
  localparam int DEF_WORD_WIDTH   = `WORD_WIDTH;
  localparam int DEF_KERNEL_W_MAX = `KERNEL_W_MAX;
  localparam int TUSER_WIDTH_MAXPOOL_IN = `TUSER_WIDTH_MAXPOOL_IN;

  localparam int I_IS_NOT_MAX = 0;
  localparam int I_IS_MAX     = 1;
  localparam int I_IS_1X1     = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_t;
endpackage

// File: rtl/maxpool_user_sequencer_if.sv
// rtl/maxpool_user_sequencer_if.sv - input and output beat streams of the maxpool sequencer
interface maxpool_user_sequencer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = 5
);
  logic                  s_axis_tvalid;
  logic                  s_axis_tready;
  logic [DATA_WIDTH-1:0] s_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic [DATA_WIDTH-1:0] m_axis_tdata;
  logic [USER_WIDTH-1:0] m_axis_tuser;
  logic                  m_axis_tlast;

  // slave: the sequencer itself; master: the conv source plus the pool engine around it
  modport slave (
    input  s_axis_tvalid, s_axis_tdata, m_axis_tready,
    output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast
  );
  modport master (
    output s_axis_tvalid, s_axis_tdata, m_axis_tready,
    input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast
  );
endinterface

// File: rtl/maxpool_seq_counter.sv
// rtl/maxpool_seq_counter.sv - column / pool-window / block position counters advanced per output beat
module maxpool_seq_counter #(
  parameter int KW_W         = 3,
  parameter int COLS_WIDTH   = 10,
  parameter int BLOCKS_WIDTH = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    adv,
  input  logic [KW_W-1:0]         kernel_w,
  input  logic [COLS_WIDTH-1:0]   cols_m1,
  output logic [COLS_WIDTH-1:0]   col,
  output logic [KW_W-1:0]         win,
  output logic [BLOCKS_WIDTH-1:0] blk,
  output logic                    col_last,
  output logic                    win_last
);
  assign col_last = (col == cols_m1);
  // a window is cut short at the end of a row so every row starts on a fresh window
  assign win_last = (win == kernel_w - KW_W'(1)) || col_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      win <= '0;
      blk <= '0;
    end else if (clr) begin
      col <= '0;
      win <= '0;
      blk <= '0;
    end else if (adv) begin
      win <= win_last ? '0 : win + KW_W'(1);
      col <= col_last ? '0 : col + COLS_WIDTH'(1);
      if (col_last) blk <= blk + BLOCKS_WIDTH'(1);
    end
  end
endmodule

// File: rtl/maxpool_user_sequencer.sv
// rtl/maxpool_user_sequencer.sv - tags conv output beats with maxpool tuser/tlast; optional MAXPOOL_SEQ_STALL_CNT_EN adds stall_count
module maxpool_user_sequencer
  import maxpool_user_sequencer_pkg::*;
#(
  parameter int UNITS        = DEF_UNITS,
  parameter int GROUPS       = DEF_GROUPS,
  parameter int WORD_WIDTH   = DEF_WORD_WIDTH,
  parameter int KERNEL_W_MAX = DEF_KERNEL_W_MAX,
  parameter int TUSER_WIDTH  = TUSER_WIDTH_MAXPOOL_IN,
  parameter int COLS_WIDTH   = 10,
  parameter int BLOCKS_WIDTH = 10,
  localparam int KW_W        = $clog2(KERNEL_W_MAX + 1),
  localparam int DATA_WIDTH  = GROUPS * UNITS * 2 * WORD_WIDTH
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [KW_W-1:0]         cfg_kernel_w,
  input  logic [COLS_WIDTH-1:0]   cfg_cols_m1,
  input  logic [BLOCKS_WIDTH-1:0] cfg_blocks_m1,
  input  logic                    cfg_is_max,
  input  logic                    cfg_is_1x1,
  maxpool_user_sequencer_if.slave axis,
  output logic                    cfg_error
`ifdef MAXPOOL_SEQ_STALL_CNT_EN
  ,
  output logic [31:0]             stall_count
`endif
);
  seq_state_t state, next_state;

  logic [KW_W-1:0]         kernel_w_q;
  logic [COLS_WIDTH-1:0]   cols_m1_q;
  logic [BLOCKS_WIDTH-1:0] blocks_m1_q;
  logic                    is_max_q;
  logic                    is_1x1_q;

  logic [COLS_WIDTH-1:0]   col;
  logic [KW_W-1:0]         win;
  logic [BLOCKS_WIDTH-1:0] blk;
  logic                    col_last, win_last;
  logic                    kw_ok, cfg_accept, cfg_reject, handshake, last_beat;

  // only odd widths give the pool a centre column
  assign kw_ok = cfg_kernel_w[0] && (32'(cfg_kernel_w) <= KERNEL_W_MAX);

  maxpool_seq_counter #(
    .KW_W(KW_W), .COLS_WIDTH(COLS_WIDTH), .BLOCKS_WIDTH(BLOCKS_WIDTH)
  ) u_counter (
    .clk(aclk), .rst_n(aresetn), .clr(cfg_accept), .adv(handshake),
    .kernel_w(kernel_w_q), .cols_m1(cols_m1_q),
    .col(col), .win(win), .blk(blk), .col_last(col_last), .win_last(win_last)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= ST_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state          = state;
    cfg_ready           = 1'b0;
    cfg_accept          = 1'b0;
    cfg_reject          = 1'b0;
    handshake           = 1'b0;
    last_beat           = 1'b0;
    axis.s_axis_tready  = 1'b0;
    axis.m_axis_tvalid  = 1'b0;
    axis.m_axis_tdata   = '0;
    axis.m_axis_tuser   = '0;
    axis.m_axis_tlast   = 1'b0;
    case (state)
      ST_IDLE: begin
        cfg_ready  = 1'b1;
        cfg_accept = cfg_valid && kw_ok;
        cfg_reject = cfg_valid && !kw_ok;
        if (cfg_accept) next_state = ST_RUN;
      end
      ST_RUN: begin
        axis.m_axis_tvalid             = axis.s_axis_tvalid;
        axis.s_axis_tready             = axis.m_axis_tready;
        axis.m_axis_tdata              = axis.s_axis_tdata;
        axis.m_axis_tuser[I_IS_MAX]     = is_max_q && win_last;
        axis.m_axis_tuser[I_IS_NOT_MAX] = !is_max_q;
        axis.m_axis_tuser[I_IS_1X1]     = is_1x1_q;
        last_beat                      = col_last && (blk == blocks_m1_q);
        axis.m_axis_tlast              = last_beat;
        handshake                      = axis.s_axis_tvalid && axis.m_axis_tready;
        if (handshake && last_beat) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      kernel_w_q  <= '0;
      cols_m1_q   <= '0;
      blocks_m1_q <= '0;
      is_max_q    <= 1'b0;
      is_1x1_q    <= 1'b0;
      cfg_error   <= 1'b0;
    end else if (cfg_accept) begin
      kernel_w_q  <= cfg_kernel_w;
      cols_m1_q   <= cfg_cols_m1;
      blocks_m1_q <= cfg_blocks_m1;
      is_max_q    <= cfg_is_max;
      is_1x1_q    <= cfg_is_1x1;
      cfg_error   <= 1'b0;
    end else if (cfg_reject) begin
      cfg_error   <= 1'b1;
    end
  end

`ifdef MAXPOOL_SEQ_STALL_CNT_EN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)
      stall_count <= '0;
    else if (cfg_accept)
      stall_count <= '0;
    else if (axis.m_axis_tvalid && !axis.m_axis_tready && (stall_count != '1))
      stall_count <= stall_count + 32'd1;
  end
`endif
endmodule

// File: tb/tb_maxpool_user_sequencer.sv
// tb/tb_maxpool_user_sequencer.sv - randomized self-checking bench for maxpool_user_sequencer (honours MAXPOOL_SEQ_STALL_CNT_EN)
module tb_maxpool_user_sequencer;
  import maxpool_user_sequencer_pkg::*;

  localparam int KW_W = $clog2(DEF_KERNEL_W_MAX + 1);
  localparam int DW   = DEF_GROUPS * DEF_UNITS * 2 * DEF_WORD_WIDTH;
  localparam int TW   = TUSER_WIDTH_MAXPOOL_IN;

  logic            aclk = 1'b0;
  logic            aresetn;
  logic            cfg_valid;
  logic            cfg_ready;
  logic [KW_W-1:0] cfg_kernel_w;
  logic [9:0]      cfg_cols_m1;
  logic [9:0]      cfg_blocks_m1;
  logic            cfg_is_max;
  logic            cfg_is_1x1;
  logic            cfg_error;
`ifdef MAXPOOL_SEQ_STALL_CNT_EN
  logic [31:0]     stall_count;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 aclk = ~aclk;

  maxpool_user_sequencer_if #(.DATA_WIDTH(DW), .USER_WIDTH(TW)) bus ();

  maxpool_user_sequencer #(
    .UNITS(DEF_UNITS), .GROUPS(DEF_GROUPS), .WORD_WIDTH(DEF_WORD_WIDTH),
    .KERNEL_W_MAX(DEF_KERNEL_W_MAX), .TUSER_WIDTH(TW),
    .COLS_WIDTH(10), .BLOCKS_WIDTH(10)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_kernel_w(cfg_kernel_w), .cfg_cols_m1(cfg_cols_m1), .cfg_blocks_m1(cfg_blocks_m1),
    .cfg_is_max(cfg_is_max), .cfg_is_1x1(cfg_is_1x1),
    .axis(bus.slave),
    .cfg_error(cfg_error)
`ifdef MAXPOOL_SEQ_STALL_CNT_EN
    , .stall_count(stall_count)
`endif
  );

  task automatic check_idle_outputs(input string tag);
    vectors++;
    if (cfg_ready !== 1'b1) begin
      miscompares++; $display("FAIL %s cfg_ready got %b want 1", tag, cfg_ready);
    end
    vectors++;
    if (bus.s_axis_tready !== 1'b0) begin
      miscompares++; $display("FAIL %s s_axis_tready got %b want 0", tag, bus.s_axis_tready);
    end
    vectors++;
    if (bus.m_axis_tvalid !== 1'b0) begin
      miscompares++; $display("FAIL %s m_axis_tvalid got %b want 0", tag, bus.m_axis_tvalid);
    end
    vectors++;
    if (bus.m_axis_tlast !== 1'b0) begin
      miscompares++; $display("FAIL %s m_axis_tlast got %b want 0", tag, bus.m_axis_tlast);
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    cfg_valid = 1'b0; cfg_kernel_w = '0; cfg_cols_m1 = '0; cfg_blocks_m1 = '0;
    cfg_is_max = 1'b0; cfg_is_1x1 = 1'b0;
    bus.s_axis_tvalid = 1'b1; bus.m_axis_tready = 1'b1; bus.s_axis_tdata = '0;
    repeat (3) @(negedge aclk);
    #1;
    check_idle_outputs("reset");
    vectors++;
    if (cfg_error !== 1'b0) begin
      miscompares++; $display("FAIL reset cfg_error got %b want 0", cfg_error);
    end
`ifdef MAXPOOL_SEQ_STALL_CNT_EN
    vectors++;
    if (stall_count !== 32'd0) begin
      miscompares++; $display("FAIL reset stall_count got %0d want 0", stall_count);
    end
`endif
    @(negedge aclk);
    aresetn = 1'b1;
  endtask

  // Offers a config, then streams the layer; returns early once abort_after beats have completed.
  task automatic run_layer(input string tag, input int kw, input int cols, input int blks,
                           input bit ismax, input bit is1x1, input bit rnd, input int abort_after);
    int total, n, stalls, cyc, col, exp_max;
    bit done, exp_last;
    logic [TW-1:0] exp_user;
    @(negedge aclk);
    cfg_kernel_w = KW_W'(kw); cfg_cols_m1 = 10'(cols); cfg_blocks_m1 = 10'(blks);
    cfg_is_max = ismax; cfg_is_1x1 = is1x1; cfg_valid = 1'b1;
    bus.s_axis_tvalid = 1'b0;
    #1;
    vectors++;
    if (cfg_ready !== 1'b1) begin
      miscompares++; $display("FAIL %s cfg_ready before accept got %b want 1", tag, cfg_ready);
    end
    @(negedge aclk);
    cfg_valid = 1'b0;
    #1;
    vectors++;
    if (cfg_error !== 1'b0) begin
      miscompares++; $display("FAIL %s cfg_error after accept got %b want 0", tag, cfg_error);
    end
    total = (cols + 1) * (blks + 1);
    n = 0; stalls = 0; cyc = 0; done = 1'b0;
    while (!done && cyc < 2000 && !(abort_after >= 0 && n == abort_after)) begin
      if (cyc != 0) @(negedge aclk);
      bus.s_axis_tvalid = rnd ? ($urandom_range(3) != 0) : 1'b1;
      bus.m_axis_tready = rnd ? 1'($urandom_range(1)) : 1'b1;
      bus.s_axis_tdata  = DW'({$urandom, $urandom});
      #1;
      col      = n % (cols + 1);
      exp_max  = (ismax && ((col % kw) == kw - 1 || col == cols)) ? 1 : 0;
      exp_last = (n == total - 1);
      exp_user = '0;
      exp_user[I_IS_MAX]     = exp_max[0];
      exp_user[I_IS_NOT_MAX] = !ismax;
      exp_user[I_IS_1X1]     = is1x1;
      vectors++;
      if (cfg_ready !== 1'b0 || bus.m_axis_tvalid !== bus.s_axis_tvalid ||
          bus.s_axis_tready !== bus.m_axis_tready) begin
        miscompares++;
        $display("FAIL %s beat %0d handshake got rdy=%b mv=%b sr=%b want 0/%b/%b", tag, n,
                 cfg_ready, bus.m_axis_tvalid, bus.s_axis_tready, bus.s_axis_tvalid, bus.m_axis_tready);
      end
      vectors++;
      if (bus.m_axis_tdata !== bus.s_axis_tdata) begin
        miscompares++; $display("FAIL %s beat %0d tdata got %h want %h", tag, n, bus.m_axis_tdata, bus.s_axis_tdata);
      end
      vectors++;
      if (bus.m_axis_tuser !== exp_user) begin
        miscompares++; $display("FAIL %s beat %0d tuser got %b want %b", tag, n, bus.m_axis_tuser, exp_user);
      end
      vectors++;
      if (bus.m_axis_tlast !== exp_last) begin
        miscompares++; $display("FAIL %s beat %0d tlast got %b want %b", tag, n, bus.m_axis_tlast, exp_last);
      end
      if (bus.s_axis_tvalid && !bus.m_axis_tready) stalls++;
      if (bus.s_axis_tvalid && bus.m_axis_tready) begin
        if (n == total - 1) done = 1'b1;
        n++;
      end
      cyc++;
    end
    if (abort_after >= 0 && n == abort_after) return;
    if (!done) begin
      vectors++; miscompares++;
      $display("FAIL %s timeout got %0d beats want %0d", tag, n, total);
      return;
    end
    @(negedge aclk);
    bus.s_axis_tvalid = 1'b1; bus.m_axis_tready = 1'b1;
    #1;
    check_idle_outputs({tag, " end"});
`ifdef MAXPOOL_SEQ_STALL_CNT_EN
    vectors++;
    if (stall_count !== 32'(stalls)) begin
      miscompares++; $display("FAIL %s stall_count got %0d want %0d", tag, stall_count, stalls);
    end
`endif
  endtask

  task automatic test_basic_layer();
    run_layer("basic_k3", 3, 5, 1, 1'b1, 1'b0, 1'b0, -1);
  endtask

  task automatic test_bad_cfg();
    int bad[4] = '{4, 0, 6, 7};
    foreach (bad[i]) begin
      @(negedge aclk);
      cfg_kernel_w = KW_W'(bad[i]); cfg_valid = 1'b1;
      #1;
      vectors++;
      if (cfg_ready !== 1'b1) begin
        miscompares++; $display("FAIL bad_cfg kw=%0d cfg_ready got %b want 1", bad[i], cfg_ready);
      end
      @(negedge aclk);
      cfg_valid = 1'b0; bus.s_axis_tvalid = 1'b1; bus.m_axis_tready = 1'b1;
      #1;
      vectors++;
      if (cfg_error !== 1'b1) begin
        miscompares++; $display("FAIL bad_cfg kw=%0d cfg_error got %b want 1", bad[i], cfg_error);
      end
      check_idle_outputs("bad_cfg");
    end
    run_layer("after_bad", 5, 6, 0, 1'b1, 1'b0, 1'b0, -1);
  endtask

  task automatic test_random_ready();
    run_layer("rnd_k3", 3, 3, 0, 1'b1, 1'b0, 1'b1, -1);
  endtask

  task automatic test_1x1();
    run_layer("one_by_one", 1, 0, 0, 1'b0, 1'b1, 1'b0, -1);
    run_layer("kw1_max", 1, 4, 1, 1'b1, 1'b0, 1'b1, -1);
  endtask

  task automatic test_reset_mid_layer();
    run_layer("pre_reset", 3, 5, 1, 1'b1, 1'b0, 1'b0, 4);
    @(negedge aclk);
    bus.s_axis_tvalid = 1'b1; bus.m_axis_tready = 1'b1;
    aresetn = 1'b0;
    #1;
    check_idle_outputs("mid_reset");
    @(negedge aclk);
    aresetn = 1'b1;
    run_layer("post_reset", 3, 5, 1, 1'b1, 1'b0, 1'b0, -1);
  endtask

  task automatic test_back_to_back();
    int kws[3] = '{1, 3, 5};
    for (int i = 0; i < 6; i++)
      run_layer("random", kws[$urandom_range(2)], $urandom_range(7), $urandom_range(2),
                1'($urandom_range(1)), 1'($urandom_range(1)), 1'b1, -1);
  endtask

  initial begin
    test_reset();
    test_basic_layer();
    test_bad_cfg();
    test_random_ready();
    test_1x1();
    test_reset_mid_layer();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
